// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - Shared geometry, constants and enums for the frame buffer arbiter
package fb_pkg;

    localparam int FB_COLS  = 40;
    localparam int FB_ROWS  = 15;
    localparam int FB_DEPTH = FB_COLS * FB_ROWS;
    localparam int FB_AW    = 10;

    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_RD   = 2'd1,
        G_WR   = 2'd2,
        G_CLR  = 2'd3
    } grant_t;

endpackage

// File: rtl/fb_arbiter_if.sv
// rtl/fb_arbiter_if.sv - Write/read request ports, clear control and RAM port of fb_arbiter
interface fb_arbiter_if #(parameter int AW = fb_pkg::FB_AW);

    logic          wr_req;
    logic [7:0]    wr_col;
    logic [7:0]    wr_row;
    logic [7:0]    wr_char;
    logic          wr_ack;

    logic          rd_req;
    logic [7:0]    rd_col;
    logic [7:0]    rd_row;
    logic          rd_ack;
    logic          rd_valid;
    logic [7:0]    rd_data;

    logic          clr_req;
    logic          clr_busy;
    logic [7:0]    drop_cnt;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    modport slave (
        input  wr_req, wr_col, wr_row, wr_char,
        input  rd_req, rd_col, rd_row,
        input  clr_req, ram_rdata,
        output wr_ack, rd_ack, rd_valid, rd_data,
        output clr_busy, drop_cnt,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output wr_req, wr_col, wr_row, wr_char,
        output rd_req, rd_col, rd_row,
        output clr_req, ram_rdata,
        input  wr_ack, rd_ack, rd_valid, rd_data,
        input  clr_busy, drop_cnt,
        input  ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/fb_addr_calc.sv
// rtl/fb_addr_calc.sv - (col,row) to linear frame buffer address with range check
module fb_addr_calc
    import fb_pkg::*;
#(
    parameter int COLS = FB_COLS,
    parameter int ROWS = FB_ROWS,
    parameter int AW   = FB_AW
) (
    input  logic [7:0]    col,
    input  logic [7:0]    row,
    output logic [AW-1:0] addr,
    output logic          in_range
);

    logic [AW-1:0] lin;

    // Out-of-range coordinates yield address 0 so nothing downstream sees garbage.
    always_comb begin
        in_range = (col < 8'(COLS)) && (row < 8'(ROWS));
        lin      = AW'(row) * AW'(COLS) + AW'(col);
        addr     = in_range ? lin : '0;
    end

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - Single-port frame buffer arbiter; FB_CLEAR_EN adds the space-fill clear engine
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int COLS        = FB_COLS,
    parameter int ROWS        = FB_ROWS,
    parameter int AW          = FB_AW,
    parameter int WR_MAX_WAIT = 4
) (
    input  logic         master_clk,
    input  logic         rst,
    fb_arbiter_if.slave  bus
);

    localparam int DEPTH = COLS * ROWS;
    localparam int WW    = $clog2(WR_MAX_WAIT + 1);

    state_t        state, state_nx;
    grant_t        grant;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          wr_in, rd_in;
    logic          wr_eff, rd_eff;
    logic [WW-1:0] wr_wait;
    logic          rd_oor0, rd_oor1, rd_p1;
    logic          clr_start, clr_last;

    fb_addr_calc #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) u_wr_calc (
        .col(bus.wr_col), .row(bus.wr_row), .addr(wr_addr), .in_range(wr_in)
    );

    fb_addr_calc #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) u_rd_calc (
        .col(bus.rd_col), .row(bus.rd_row), .addr(rd_addr), .in_range(rd_in)
    );

    // A port acked this cycle is masked for one cycle so it can drop req on seeing ack.
    assign wr_eff   = bus.wr_req & ~bus.wr_ack;
    assign rd_eff   = bus.rd_req & ~bus.rd_ack;
    assign clr_last = (bus.ram_addr == AW'(DEPTH - 1));

`ifdef FB_CLEAR_EN
    logic boot_pend;

    // Forces one clear on the first edge after reset release.
    always_ff @(posedge master_clk or posedge rst) begin
        if (rst) boot_pend <= 1'b1;
        else     boot_pend <= 1'b0;
    end

    assign clr_start    = bus.clr_req | boot_pend;
    assign bus.clr_busy = (state == CLEAR);
`else
    assign clr_start    = 1'b0;
    assign bus.clr_busy = 1'b0;
`endif

    always_ff @(posedge master_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant    = G_NONE;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    grant    = G_CLR;
                    state_nx = CLEAR;
                end else if (wr_eff && wr_wait == WW'(WR_MAX_WAIT)) begin
                    grant = G_WR;
                end else if (rd_eff) begin
                    grant = G_RD;
                end else if (wr_eff) begin
                    grant = G_WR;
                end
            end
            CLEAR: begin
                if (clr_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge master_clk or posedge rst) begin
        if (rst) begin
            bus.wr_ack    <= 1'b0;
            bus.rd_ack    <= 1'b0;
            bus.rd_valid  <= 1'b0;
            bus.rd_data   <= '0;
            bus.drop_cnt  <= '0;
            bus.ram_addr  <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_wdata <= '0;
            wr_wait       <= '0;
            rd_oor0       <= 1'b0;
            rd_oor1       <= 1'b0;
            rd_p1         <= 1'b0;
        end else begin
            bus.wr_ack    <= (grant == G_WR);
            bus.rd_ack    <= (grant == G_RD);
            bus.ram_we    <= 1'b0;
            bus.ram_wdata <= '0;

            // Read pipeline: address in G, RAM data arrives in G+1, result presented in G+2.
            rd_oor0      <= (grant == G_RD) && !rd_in;
            rd_p1        <= bus.rd_ack;
            rd_oor1      <= rd_oor0;
            bus.rd_valid <= rd_p1;
            if (rd_p1) bus.rd_data <= rd_oor1 ? CHAR_SPACE : bus.ram_rdata;

            if (grant == G_WR)
                wr_wait <= '0;
            else if (bus.wr_req && wr_wait != WW'(WR_MAX_WAIT))
                wr_wait <= wr_wait + 1'b1;

            case (grant)
                G_WR: begin
                    if (wr_in) begin
                        bus.ram_addr  <= wr_addr;
                        bus.ram_we    <= 1'b1;
                        bus.ram_wdata <= bus.wr_char;
                    end else if (bus.drop_cnt != 8'hFF) begin
                        bus.drop_cnt <= bus.drop_cnt + 1'b1;
                    end
                end
                G_RD: begin
                    if (rd_in) bus.ram_addr <= rd_addr;
                end
                G_CLR: begin
                    bus.ram_addr  <= '0;
                    bus.ram_we    <= 1'b1;
                    bus.ram_wdata <= CHAR_SPACE;
                end
                default: begin
                    if (state == CLEAR && !clr_last) begin
                        bus.ram_addr  <= bus.ram_addr + 1'b1;
                        bus.ram_we    <= 1'b1;
                        bus.ram_wdata <= CHAR_SPACE;
                    end
                end
            endcase
        end
    end

endmodule
